reg_file_write_ctrl: RTL and testbench

//  Owns the single write port (W_Adr/we/W) of the 8x16 register file.

---
 rtl/reg_file_write_ctrl.sv | 150 +++++++++++++++
 tb/tb_reg_file_write_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_write_ctrl.sv
// Write-port controller for the 8x16 register file.
// Arbitrates ALU (A) and load (B) write-backs round-robin and runs a
// clear-all sequence that zeroes every register, one write per cycle.
`timescale 1ns/1ps

module reg_file_write_ctrl #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_start,
  output logic              clr_busy,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_adr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ack,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_adr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ack,
  output logic [ADDR_W-1:0] W_Adr,
  output logic              we,
  output logic [DATA_W-1:0] W
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(NUM_REGS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ptr_q, ptr_d;   // 0: A wins next contest, 1: B wins
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   wadr_q, wadr_d;
  logic [DATA_W-1:0]   w_q, w_d;
  logic                a_ack_q, a_ack_d;
  logic                b_ack_q, b_ack_d;
  logic                busy_q, busy_d;

  // A requester whose ack is on the port this cycle is not eligible again yet
  logic a_elig, b_elig, grant_a, grant_b;

  // Next-state, arbitration and registered-output computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    wadr_d  = wadr_q;
    w_d     = w_q;
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;
    busy_d  = 1'b0;
    a_elig  = a_req & ~a_ack_q;
    b_elig  = b_req & ~b_ack_q;
    grant_a = 1'b0;
    grant_b = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          // Entry edge already issues the write to address 0
          we_d   = 1'b1;
          wadr_d = '0;
          w_d    = '0;
          busy_d = 1'b1;
          if (NUM_REGS > 1) begin
            state_d = ST_CLEAR;
            cnt_d   = ADDR_W'(1);
          end
        end else if (a_elig && b_elig) begin
          grant_a = ~ptr_q;
          grant_b = ptr_q;
          ptr_d   = ~ptr_q;
        end else begin
          grant_a = a_elig;
          grant_b = b_elig;
        end

        if (grant_a) begin
          we_d    = 1'b1;
          wadr_d  = a_adr;
          w_d     = a_data;
          a_ack_d = 1'b1;
        end else if (grant_b) begin
          we_d    = 1'b1;
          wadr_d  = b_adr;
          w_d     = b_data;
          b_ack_d = 1'b1;
        end
      end

      ST_CLEAR: begin
        we_d   = 1'b1;
        wadr_d = cnt_q;
        w_d    = '0;
        busy_d = 1'b1;
        if (cnt_q == LAST_ADR) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      we_q    <= 1'b0;
      wadr_q  <= '0;
      w_q     <= '0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      wadr_q  <= wadr_d;
      w_q     <= w_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
      busy_q  <= busy_d;
    end
  end

  assign we       = we_q;
  assign W_Adr    = wadr_q;
  assign W        = w_q;
  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign clr_busy = busy_q;

endmodule

// File: tb/tb_reg_file_write_ctrl.sv
// Directed testbench for reg_file_write_ctrl with a register-file model
// that captures whatever the controller puts on the write port.
`timescale 1ns/1ps

module tb_reg_file_write_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr_start;
  logic        clr_busy;
  logic        a_req;
  logic [2:0]  a_adr;
  logic [15:0] a_data;
  logic        a_ack;
  logic        b_req;
  logic [2:0]  b_adr;
  logic [15:0] b_data;
  logic        b_ack;
  logic [2:0]  W_Adr;
  logic        we;
  logic [15:0] W;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] rf [8];
  logic [22:0] obs;

  assign obs = {we, a_ack, b_ack, clr_busy, W_Adr, W};

  always #5 clk = ~clk;

  reg_file_write_ctrl #(.DATA_W(16), .ADDR_W(3), .NUM_REGS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .a_req     (a_req),
    .a_adr     (a_adr),
    .a_data    (a_data),
    .a_ack     (a_ack),
    .b_req     (b_req),
    .b_adr     (b_adr),
    .b_data    (b_data),
    .b_ack     (b_ack),
    .W_Adr     (W_Adr),
    .we        (we),
    .W         (W)
  );

  // Register file: non-zero fill on reset so a clear is observable
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'hFFFF;
    end else if (we) begin
      rf[W_Adr] <= W;
    end
  end

  function automatic logic [22:0] mk(input logic e, input logic aa, input logic ba,
                                     input logic bz, input logic [2:0] ad,
                                     input logic [15:0] d);
    return {e, aa, ba, bz, ad, d};
  endfunction

  task automatic test_reset();
    logic [22:0] exp;
    reset = 1'b1; clr_start = 1'b0;
    a_req = 1'b0; a_adr = '0; a_data = '0;
    b_req = 1'b0; b_adr = '0; b_data = '0;
    @(posedge clk); #1;
    exp = mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL reset_state: got %h want %h", obs, exp); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_single_write();
    logic [22:0] exp;
    @(negedge clk); a_req = 1'b1; a_adr = 3'd3; a_data = 16'hBEEF;
    @(posedge clk); #1;
    exp = mk(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 16'hBEEF);
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL single_a: got %h want %h", obs, exp); end
    @(negedge clk); a_req = 1'b0;
    @(posedge clk); #1;
    exp = mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'hBEEF);
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL single_idle_hold: got %h want %h", obs, exp); end
  endtask

  task automatic test_back_to_back();
    logic [22:0] exp;
    @(negedge clk);
    a_req = 1'b1; a_adr = 3'd1; a_data = 16'h1111;
    b_req = 1'b1; b_adr = 3'd2; b_data = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      exp = (i % 2 == 0) ? mk(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 16'h1111)
                         : mk(1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 16'h2222);
      n_tests++;
      if (obs !== exp) begin n_fail++; $display("FAIL b2b_grant%0d: got %h want %h", i, obs, exp); end
    end
    @(negedge clk); a_req = 1'b0; b_req = 1'b0;
    @(posedge clk); #1;
    exp = mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 16'h2222);
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL b2b_idle: got %h want %h", obs, exp); end
  endtask

  // Pointer was flipped to B by the one contested grant of the previous test
  task automatic test_pointer();
    logic [22:0] exp;
    @(negedge clk);
    a_req = 1'b1; a_adr = 3'd4; a_data = 16'hAAAA;
    b_req = 1'b1; b_adr = 3'd6; b_data = 16'hBBBB;
    @(posedge clk); #1;
    exp = mk(1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 16'hBBBB);
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL ptr_b_first: got %h want %h", obs, exp); end
    @(negedge clk); b_req = 1'b0;
    @(posedge clk); #1;
    exp = mk(1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 16'hAAAA);
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL ptr_a_second: got %h want %h", obs, exp); end
    @(negedge clk); a_req = 1'b0;
    @(posedge clk); #1;
    // Same target from both sides: A wins the contest, B's write lands last
    @(negedge clk);
    a_req = 1'b1; a_adr = 3'd7; a_data = 16'h7A7A;
    b_req = 1'b1; b_adr = 3'd7; b_data = 16'h7B7B;
    @(posedge clk); #1;
    exp = mk(1'b1, 1'b1, 1'b0, 1'b0, 3'd7, 16'h7A7A);
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL same_adr_a: got %h want %h", obs, exp); end
    @(negedge clk); a_req = 1'b0;
    @(posedge clk); #1;
    exp = mk(1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 16'h7B7B);
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL same_adr_b: got %h want %h", obs, exp); end
    @(negedge clk); b_req = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (rf[7] !== 16'h7B7B) begin n_fail++; $display("FAIL same_adr_last_wins: got %h want %h", rf[7], 16'h7B7B); end
  endtask

  task automatic test_clear();
    logic [22:0] exp;
    @(negedge clk); clr_start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      exp = mk(1'b1, 1'b0, 1'b0, 1'b1, 3'(i), 16'h0000);
      n_tests++;
      if (obs !== exp) begin n_fail++; $display("FAIL clear_step%0d: got %h want %h", i, obs, exp); end
      @(negedge clk); clr_start = 1'b0;
    end
    @(posedge clk); #1;
    exp = mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 16'h0000);
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL clear_done: got %h want %h", obs, exp); end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (rf[i] !== 16'h0000) begin n_fail++; $display("FAIL clear_readback%0d: got %h want %h", i, rf[i], 16'h0000); end
    end
  endtask

  task automatic test_req_during_clear();
    logic [22:0] exp;
    @(negedge clk); clr_start = 1'b1;
    @(posedge clk); #1;
    exp = mk(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000);
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL rdc_step0: got %h want %h", obs, exp); end
    @(negedge clk); clr_start = 1'b0;
    a_req = 1'b1; a_adr = 3'd5; a_data = 16'h5A5A;
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      exp = mk(1'b1, 1'b0, 1'b0, 1'b1, 3'(i), 16'h0000);
      n_tests++;
      if (obs !== exp) begin n_fail++; $display("FAIL rdc_step%0d: got %h want %h", i, obs, exp); end
    end
    @(posedge clk); #1;
    exp = mk(1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 16'h5A5A);
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL rdc_a_after: got %h want %h", obs, exp); end
    @(negedge clk); a_req = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (rf[5] !== 16'h5A5A) begin n_fail++; $display("FAIL rdc_rf5: got %h want %h", rf[5], 16'h5A5A); end
  endtask

  task automatic test_reset_mid_clear();
    logic [22:0] exp;
    @(negedge clk); clr_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      exp = mk(1'b1, 1'b0, 1'b0, 1'b1, 3'(i), 16'h0000);
      n_tests++;
      if (obs !== exp) begin n_fail++; $display("FAIL rmc_step%0d: got %h want %h", i, obs, exp); end
      @(negedge clk); clr_start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    exp = mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL rmc_reset: got %h want %h", obs, exp); end
    @(negedge clk); reset = 1'b0; clr_start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      exp = mk(1'b1, 1'b0, 1'b0, 1'b1, 3'(i), 16'h0000);
      n_tests++;
      if (obs !== exp) begin n_fail++; $display("FAIL rmc_restart%0d: got %h want %h", i, obs, exp); end
      @(negedge clk); clr_start = 1'b0;
    end
    @(posedge clk); #1;
    exp = mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 16'h0000);
    n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL rmc_done: got %h want %h", obs, exp); end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (rf[i] !== 16'h0000) begin n_fail++; $display("FAIL rmc_readback%0d: got %h want %h", i, rf[i], 16'h0000); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_pointer();
    test_clear();
    test_req_during_clear();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
